mtx_dispatch: RTL and testbench
===============================

MTX_DISPATCH -- requirements
Module: mtx_dispatch

Interface
REQ-001 Parameter PDEPTH, default 16, program buffer depth in VLIW words (power of two, 2..64).
REQ-002 Parameter LW, default 8, loop-count width in bits.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 prog_we / prog_addr / prog_wdata  input  1 / clog2(PDEPTH) / vliw_inst_t  program buffer write port.
REQ-006 start / abort  input  1 / 1  begin / cancel a run.
REQ-007 prog_len / loop_cnt  input  clog2(PDEPTH)+1 / LW  words per pass / extra passes; both sampled at start.
REQ-008 din_valid / din_ready / din  input / output / input  1 / 1 / mv_t  operand stream, valid-ready.
REQ-009 vliw_inst / mtx_in  output  vliw_inst_t / mv_t  registered drive to the matrix unit's instruction and data inputs.
REQ-010 mtx_out / st  input  mv_t / status_t  matrix unit result and status.
REQ-011 res_valid / res  output  1 / mv_t  captured store result.
REQ-012 busy / done / err  output  1 each  running; one-cycle completion pulse; one-cycle error pulse.

Function
REQ-013 FSM states IDLE, RUN, DRAIN, DONE; IDLE is the reset state.
REQ-014 IDLE: start=1 with prog_len in 1..PDEPTH -> RUN, pc=0, iter=0; any other prog_len -> err=1 for one cycle, stay IDLE.
REQ-015 Word "needs data" iff any of its four op fields is LD_V0, LD_V1 or LD_M0.
REQ-016 RUN, word at pc needs no data: next edge registers word into vliw_inst; pc advances.
REQ-017 RUN, word needs data and din_valid=1: din_ready=1 combinationally; next edge registers word into vliw_inst and din into mtx_in; pc advances.
REQ-018 RUN, word needs data and din_valid=0: stall; next edge registers an all-NOP word; pc holds; din_ready=0.
REQ-019 din_ready is 0 in every state other than RUN; mtx_in holds its last value when no beat is consumed.
REQ-020 Issue of word pc=prog_len-1: iter<loop_cnt -> pc=0, iter+1; iter==loop_cnt -> DRAIN.
REQ-021 Total issued non-stall words = prog_len*(loop_cnt+1).
REQ-022 DRAIN: one cycle issuing all-NOP, then DONE; DONE: done=1 for one cycle, then IDLE.
REQ-023 res_valid=1 exactly in the cycle after a word containing any ST_* op is registered to the matrix unit plus one edge (matrix output settled); res = mtx_out in that cycle.
REQ-024 busy=1 in RUN, DRAIN and DONE.
REQ-025 vliw_inst is all-NOP whenever state is IDLE or DONE.
REQ-026 abort=1 in any non-IDLE state: next state IDLE, next vliw_inst all-NOP, no done pulse; abort has priority over start and stall.
REQ-027 start while busy is ignored; prog_we while busy is ignored and pulses err.
REQ-028 prog_we in IDLE writes the buffer at the next edge; a word written in the same cycle as start is visible to the run.

Reset
REQ-029 rst_n=0, at any time including mid-run: state IDLE, pc=0, iter=0, vliw_inst all-NOP, mtx_in=0, res_valid=0, busy=0, done=0, err=0, din_ready=0.
REQ-030 Program buffer contents are not reset.

Configuration
REQ-031 Macro MTX_DISPATCH_STATUS_EN defined: in RUN or DRAIN, st.inv=1 or st.of=1 -> next state IDLE, all-NOP issued, err=1 for one cycle, no done.
REQ-032 MTX_DISPATCH_STATUS_EN undefined: the st port exists but is ignored; runs end only through DONE, abort or reset.

Verification
REQ-033 prog_len=3, loop_cnt=0, no LD ops, start -> three words issued on consecutive edges, one NOP (DRAIN), done pulse, busy for exactly 5 cycles.
REQ-034 Word 0 = {LD_V0,NOP,NOP,NOP}, din_valid low for 4 cycles then high -> 4 all-NOP stall words, then word 0 with mtx_in=din, din_ready high for exactly 1 cycle.
REQ-035 prog_len=2, loop_cnt=2, word 1 contains ST_V0 -> 6 non-stall issues, res_valid pulses 3 times, each with res equal to mtx_out.
REQ-036 abort asserted in the 2nd RUN cycle -> IDLE next cycle, all-NOP issued, no done, busy low.
REQ-037 prog_len=0 start -> err pulse, busy stays 0; prog_we during RUN -> err pulse, buffer unchanged.
REQ-038 With MTX_DISPATCH_STATUS_EN, st.of=1 forced mid-run -> IDLE, err pulse, no done; without the macro, same stimulus -> run completes with done.

Source files
------------

// File: rtl/mtx_dispatch.sv
// mtx_dispatch: VLIW program sequencer for the matrix unit.
// Holds a small program buffer, issues one word per cycle while running,
// stalls on operand-load words until a data beat is available, repeats
// the program loop_cnt extra times, then drains one NOP and pulses done.
// Build option: define MTX_DISPATCH_STATUS_EN to abort a run with an
// error pulse when the matrix unit reports invalid/overflow status.

package mtx_dispatch_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        LD_V0 = 4'd1,
        LD_V1 = 4'd2,
        LD_M0 = 4'd3,
        ST_V0 = 4'd4,
        ST_V1 = 4'd5,
        ST_M0 = 4'd6,
        MUL   = 4'd7,
        ADD   = 4'd8,
        MAC   = 4'd9
    } op_t;

    typedef struct packed {
        op_t op3;
        op_t op2;
        op_t op1;
        op_t op0;
    } vliw_inst_t;

    typedef logic [31:0] mv_t;

    typedef struct packed {
        logic inv;
        logic of;
        logic zero;
        logic sat;
    } status_t;

    localparam vliw_inst_t VLIW_NOP = '{op3: NOP, op2: NOP, op1: NOP, op0: NOP};

    function automatic logic is_ld(input op_t op);
        return (op == LD_V0) || (op == LD_V1) || (op == LD_M0);
    endfunction

    function automatic logic is_st(input op_t op);
        return (op == ST_V0) || (op == ST_V1) || (op == ST_M0);
    endfunction

    function automatic logic needs_data(input vliw_inst_t w);
        return is_ld(w.op0) || is_ld(w.op1) || is_ld(w.op2) || is_ld(w.op3);
    endfunction

    function automatic logic has_store(input vliw_inst_t w);
        return is_st(w.op0) || is_st(w.op1) || is_st(w.op2) || is_st(w.op3);
    endfunction

endpackage

// States:
//   IDLE  | waiting for start; program buffer writable
//   RUN   | issuing program words, stalling on loads without data
//   DRAIN | one trailing NOP so the last word completes
//   DONE  | done pulse, back to IDLE next cycle
module mtx_dispatch
    import mtx_dispatch_pkg::*;
#(
    parameter int PDEPTH = 16,
    parameter int LW     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        prog_we,
    input  logic [$clog2(PDEPTH)-1:0]   prog_addr,
    input  vliw_inst_t                  prog_wdata,
    input  logic                        start,
    input  logic                        abort,
    input  logic [$clog2(PDEPTH):0]     prog_len,
    input  logic [LW-1:0]               loop_cnt,
    input  logic                        din_valid,
    output logic                        din_ready,
    input  mv_t                         din,
    output vliw_inst_t                  vliw_inst,
    output mv_t                         mtx_in,
    input  mv_t                         mtx_out,
    input  status_t                     st,
    output logic                        res_valid,
    output mv_t                         res,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int AW = $clog2(PDEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [AW-1:0]    pc;
    logic [LW-1:0]    iter;
    logic [AW:0]      len_q;
    logic [LW-1:0]    loop_q;
    mv_t              res_hold;
    vliw_inst_t       prog_mem [PDEPTH];

    vliw_inst_t       cur_word;
    logic             word_ld;
    logic             last_word;
    logic             len_ok;
    logic             status_fault;

    assign cur_word  = prog_mem[pc];
    assign word_ld   = needs_data(cur_word);
    assign last_word = ({1'b0, pc} == (len_q - 1'b1));
    assign len_ok    = (prog_len != '0) && (prog_len <= (AW+1)'(PDEPTH));
    assign busy      = (state != IDLE);

`ifdef MTX_DISPATCH_STATUS_EN
    assign status_fault = ((state == RUN) || (state == DRAIN)) && (st.inv || st.of);
`else
    logic st_unused;
    assign st_unused    = ^st;
    assign status_fault = 1'b0;
`endif

    // Beat is consumed only when the current word actually issues this edge.
    assign din_ready = (state == RUN) && word_ld && din_valid && !abort && !status_fault;

    // The result is live from the matrix unit in its valid cycle and held afterwards.
    assign res = res_valid ? mtx_out : res_hold;

    // Program buffer write port; only accepted while idle, contents survive reset.
    always_ff @(posedge clk) begin
        if (prog_we && (state == IDLE)) begin
            prog_mem[prog_addr] <= prog_wdata;
        end
    end

    // Store results appear one edge after the store word reaches the matrix unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_hold  <= '0;
        end else begin
            res_valid <= has_store(vliw_inst);
            if (res_valid) begin
                res_hold <= mtx_out;
            end
        end
    end

    // Sequencer FSM with registered instruction/data drive and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            iter      <= '0;
            len_q     <= '0;
            loop_q    <= '0;
            vliw_inst <= VLIW_NOP;
            mtx_in    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= prog_we && (state != IDLE);
            if ((state != IDLE) && abort) begin
                state     <= IDLE;
                vliw_inst <= VLIW_NOP;
                pc        <= '0;
                iter      <= '0;
            end else if (status_fault) begin
                state     <= IDLE;
                vliw_inst <= VLIW_NOP;
                pc        <= '0;
                iter      <= '0;
                err       <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        vliw_inst <= VLIW_NOP;
                        if (start) begin
                            if (len_ok) begin
                                state  <= RUN;
                                pc     <= '0;
                                iter   <= '0;
                                len_q  <= prog_len;
                                loop_q <= loop_cnt;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (word_ld && !din_valid) begin
                            vliw_inst <= VLIW_NOP;
                        end else begin
                            vliw_inst <= cur_word;
                            if (word_ld) begin
                                mtx_in <= din;
                            end
                            if (last_word) begin
                                pc <= '0;
                                if (iter == loop_q) begin
                                    state <= DRAIN;
                                end else begin
                                    iter <= iter + 1'b1;
                                end
                            end else begin
                                pc <= pc + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        vliw_inst <= VLIW_NOP;
                        state     <= DONE;
                        done      <= 1'b1;
                    end
                    DONE: begin
                        vliw_inst <= VLIW_NOP;
                        state     <= IDLE;
                    end
                    default: begin
                        vliw_inst <= VLIW_NOP;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mtx_dispatch.sv
// Testbench for mtx_dispatch: the stimulus side pushes the expected issued
// words and data beats into queues from a plain program model; a negedge
// monitor pops and compares whenever a non-NOP word reaches the matrix unit.

module tb_mtx_dispatch;
    import mtx_dispatch_pkg::*;

    localparam int PDEPTH = 16;
    localparam int LW     = 8;
    localparam int AW     = 4;
`ifdef MTX_DISPATCH_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    vliw_inst_t    prog_wdata;
    logic          start;
    logic          abort;
    logic [AW:0]   prog_len;
    logic [LW-1:0] loop_cnt;
    logic          din_valid;
    logic          din_ready;
    mv_t           din;
    vliw_inst_t    vliw_inst;
    mv_t           mtx_in;
    mv_t           mtx_out;
    status_t       st;
    logic          res_valid;
    mv_t           res;
    logic          busy;
    logic          done;
    logic          err;

    mtx_dispatch #(.PDEPTH(PDEPTH), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .start(start), .abort(abort), .prog_len(prog_len), .loop_cnt(loop_cnt),
        .din_valid(din_valid), .din_ready(din_ready), .din(din),
        .vliw_inst(vliw_inst), .mtx_in(mtx_in), .mtx_out(mtx_out), .st(st),
        .res_valid(res_valid), .res(res), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    vliw_inst_t exp_q[$];
    mv_t        exp_d[$];
    vliw_inst_t model_mem [PDEPTH];

    int n_issue, n_done, n_err, n_res, n_ready, n_busy, n_busy_nop;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, req);
        end
    endtask

    function automatic bit tb_ld(input vliw_inst_t w);
        logic [15:0] b;
        op_t o;
        b = w;
        for (int f = 0; f < 4; f++) begin
            o = op_t'(b[f*4 +: 4]);
            if (o == LD_V0 || o == LD_V1 || o == LD_M0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit tb_st(input vliw_inst_t w);
        logic [15:0] b;
        op_t o;
        b = w;
        for (int f = 0; f < 4; f++) begin
            o = op_t'(b[f*4 +: 4]);
            if (o == ST_V0 || o == ST_V1 || o == ST_M0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Random word that is never all-NOP, so stalls stay distinguishable.
    function automatic vliw_inst_t tb_rand_word(input bit allow_ld);
        logic [15:0] b;
        int o;
        for (int f = 0; f < 4; f++) begin
            o = $urandom_range(0, 9);
            if (!allow_ld && o >= 1 && o <= 3) o = 7;
            b[f*4 +: 4] = 4'(o);
        end
        if (b == 16'h0) b[3:0] = 4'd8;
        return vliw_inst_t'(b);
    endfunction

    task automatic clr();
        n_issue = 0; n_done = 0; n_err = 0; n_res = 0;
        n_ready = 0; n_busy = 0; n_busy_nop = 0;
    endtask

    // Matrix unit output: fresh random value every cycle.
    always begin
        @(posedge clk);
        #1;
        mtx_out = $urandom;
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) n_busy++;
            if (busy && vliw_inst == VLIW_NOP) n_busy_nop++;
            if (done) n_done++;
            if (err) n_err++;
            if (din_ready) n_ready++;
            if (res_valid) begin
                n_res++;
                chk("res_value", int'(res), int'(mtx_out));
            end
            if (vliw_inst != VLIW_NOP) begin
                n_issue++;
                chk("issue_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    vliw_inst_t w;
                    w = exp_q.pop_front();
                    chk("issue_word", int'(vliw_inst), int'(w));
                    if (tb_ld(w)) begin
                        chk("beat_expected", (exp_d.size() > 0) ? 1 : 0, 1);
                        if (exp_d.size() > 0) chk("mtx_in", int'(mtx_in), int'(exp_d.pop_front()));
                    end
                end
            end
        end
    end

    task automatic write_word(input int a, input vliw_inst_t w);
        @(posedge clk); #1;
        prog_we = 1'b1; prog_addr = AW'(a); prog_wdata = w;
        @(posedge clk); #1;
        prog_we = 1'b0;
        model_mem[a] = w;
    endtask

    task automatic run(input int len, input int lc, input int vprob, input int hold,
                       input int abort_at, input int we_at, input int st_at,
                       input bit ws, input vliw_inst_t ws_word);
        vliw_inst_t flat[$];
        mv_t        stream[$];
        vliw_inst_t wr;
        mv_t        v;
        int         bi, nst, cut, exp_err;
        bit         stop_early, finished, hs;
        bi = 0; nst = 0; finished = 1'b0;
        if (ws) model_mem[0] = ws_word;
        for (int p = 0; p <= lc; p++)
            for (int i = 0; i < len; i++) flat.push_back(model_mem[i]);
        stop_early = (abort_at >= 0) || (st_at >= 0 && STATUS_EN);
        cut = (abort_at >= 0) ? abort_at : st_at;
        if (stop_early)
            while (flat.size() > cut) void'(flat.pop_back());
        foreach (flat[j]) begin
            exp_q.push_back(flat[j]);
            if (tb_ld(flat[j])) begin
                v = $urandom;
                stream.push_back(v);
                exp_d.push_back(v);
            end
            if (tb_st(flat[j])) nst++;
        end
        exp_err = ((we_at >= 0) ? 1 : 0) + ((st_at >= 0 && STATUS_EN) ? 1 : 0);
        do wr = tb_rand_word(1'b1); while (wr == model_mem[0]);
        clr();
        @(posedge clk); #1;
        start = 1'b1; prog_len = (AW+1)'(len); loop_cnt = LW'(lc);
        if (ws) begin prog_we = 1'b1; prog_addr = '0; prog_wdata = ws_word; end
        @(posedge clk); #1;
        start = 1'b0; prog_we = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            din_valid  = (bi < stream.size()) && (k >= hold) && ($urandom_range(0, 99) < vprob);
            din        = (bi < stream.size()) ? stream[bi] : mv_t'($urandom);
            abort      = (k == abort_at);
            st         = '0;
            st.of      = (k == st_at);
            prog_we    = (k == we_at);
            prog_addr  = '0;
            prog_wdata = wr;
            #1;
            hs = din_valid && din_ready;
            @(posedge clk); #1;
            if (hs) bi++;
            if (k == abort_at || (stop_early && k == st_at)) begin
                chk("stop_busy", int'(busy), 0);
                chk("stop_nop", int'(vliw_inst), 0);
                finished = 1'b1;
                break;
            end
            if (done) begin
                finished = 1'b1;
                break;
            end
        end
        abort = 1'b0; st = '0; prog_we = 1'b0; din_valid = 1'b0;
        if (!finished) chk("run_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("words_left", exp_q.size(), 0);
        chk("beats_left", exp_d.size(), 0);
        chk("issue_count", n_issue, flat.size());
        chk("beats_used", bi, stream.size());
        chk("ready_cycles", n_ready, stream.size());
        chk("done_pulses", n_done, stop_early ? 0 : 1);
        chk("res_pulses", n_res, nst);
        chk("err_pulses", n_err, exp_err);
        chk("idle_after", int'(busy), 0);
        exp_q.delete();
        exp_d.delete();
    endtask

    task automatic bad_start(input int len);
        clr();
        @(posedge clk); #1;
        start = 1'b1; prog_len = (AW+1)'(len);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("badlen_err", n_err, 1);
        chk("badlen_busy", n_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = VLIW_NOP;
        start = 1'b0; abort = 1'b0; prog_len = '0; loop_cnt = '0;
        din_valid = 1'b0; din = '0; mtx_out = '0; st = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vliw", int'(vliw_inst), 0);
        chk("rst_mtx_in", int'(mtx_in), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_din_ready", int'(din_ready), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < PDEPTH; i++) write_word(i, tb_rand_word(1'b0));

        // Three plain words, single pass.
        run(3, 0, 100, 0, -1, -1, -1, 1'b0, VLIW_NOP);
        chk("busy_cycles_3", n_busy, 5);

        // Load word with data held off for four cycles.
        write_word(0, vliw_inst_t'(16'h1000));
        run(1, 0, 100, 4, -1, -1, -1, 1'b0, VLIW_NOP);
        chk("stall_nop_cycles", n_busy_nop, 6);
        chk("busy_cycles_stall", n_busy, 7);

        // Two-word loop of three passes with a store in word 1.
        write_word(0, vliw_inst_t'(16'h0078));
        write_word(1, vliw_inst_t'(16'h0004));
        run(2, 2, 100, 0, -1, -1, -1, 1'b0, VLIW_NOP);
        chk("store_pulses", n_res, 3);

        // Abort in the second RUN cycle.
        for (int i = 0; i < 4; i++) write_word(i, tb_rand_word(1'b0));
        run(4, 0, 100, 0, 1, -1, -1, 1'b0, VLIW_NOP);

        // Illegal lengths, then a write while running must leave the buffer intact.
        bad_start(0);
        bad_start(PDEPTH + 1);
        run(4, 1, 100, 0, -1, 1, -1, 1'b0, VLIW_NOP);
        run(4, 0, 100, 0, -1, -1, -1, 1'b0, VLIW_NOP);

        // Word 0 written in the same cycle as start.
        run(3, 0, 100, 0, -1, -1, -1, 1'b1, tb_rand_word(1'b0));

        // Matrix overflow status mid-run.
        run(6, 0, 100, 0, -1, -1, 2, 1'b0, VLIW_NOP);

        // Reset in the middle of a run.
        clr();
        for (int i = 0; i < 8; i++) exp_q.push_back(model_mem[i]);
        @(posedge clk); #1;
        start = 1'b1; prog_len = 5'd8; loop_cnt = '0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_vliw", int'(vliw_inst), 0);
        chk("midrst_mtx_in", int'(mtx_in), 0);
        chk("midrst_din_ready", int'(din_ready), 0);
        chk("midrst_res_valid", int'(res_valid), 0);
        exp_q.delete();
        exp_d.delete();
        #4;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Random programs, lengths, loop counts and data availability.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < PDEPTH; i++) write_word(i, tb_rand_word(1'b1));
            run($urandom_range(1, PDEPTH), $urandom_range(0, 3), $urandom_range(30, 100),
                0, -1, -1, -1, 1'b0, VLIW_NOP);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
